// File: rtl/layer_mem_ctrl_pkg.sv
// Shared types for the layer memory controller: FSM states, memory
// opcodes and the pooled feature-map size helper.
package layer_mem_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_STORE    = 3'd1,
        S_POOL     = 3'd2,
        S_POOL_CLR = 3'd3,
        S_LOAD     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_STORE = 2'd1,
        OP_POOL  = 2'd2,
        OP_LOAD  = 2'd3
    } op_t;

    function automatic int pooled_size(input int w);
        return (w / 2) * (w / 2);
    endfunction

    localparam int POOLED_SIZE = pooled_size(28);

    // Memory operation owned by each state.
    function automatic op_t mem_op(input state_t s);
        case (s)
            S_STORE: return OP_STORE;
            S_POOL:  return OP_POOL;
            S_LOAD:  return OP_LOAD;
            default: return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/layer_mem_ctrl_if.sv
// Producer / layer-memory / consumer bundle of the layer controller.
// master: controller side; slave: producer, memory and consumer side.
interface layer_mem_ctrl_if #(
    parameter int ADDR_LEN = 9
);
    logic                conv_valid;
    logic                conv_ready;
    logic                store;
    logic [3:0]          out_c;
    logic [ADDR_LEN:0]   w_addr;
    logic                pool;
    logic                pool_done;
    logic                load;
    logic [ADDR_LEN:0]   addr1;
    logic [ADDR_LEN:0]   addr2;
    logic                next_ready;

    modport master (
        input  conv_valid, pool_done, next_ready,
        output conv_ready, store, out_c, w_addr,
        output pool, load, addr1, addr2
    );

    modport slave (
        output conv_valid, pool_done, next_ready,
        input  conv_ready, store, out_c, w_addr,
        input  pool, load, addr1, addr2
    );
endinterface

// File: rtl/layer_mem_ctrl_addr_pair_gen.sv
// Read pointer for the LOAD phase: steps by two per accepted pair.
// Ports: clk, rst (async low), i_clr, i_adv -> o_rp, o_last.
module addr_pair_gen #(
    parameter int ADDR_LEN = 9,
    parameter int LAST     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_adv,
    output logic [ADDR_LEN:0] o_rp,
    output logic              o_last
);
    localparam logic [ADDR_LEN:0] L_LAST = (ADDR_LEN + 1)'(LAST);
    localparam logic [ADDR_LEN:0] L_STEP = (ADDR_LEN + 1)'(2);

    logic [ADDR_LEN:0] r_rp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rp <= '0;
        end else if (i_clr) begin
            r_rp <= '0;
        end else if (i_adv) begin
            r_rp <= r_rp + L_STEP;
        end
    end

    assign o_rp   = r_rp;
    assign o_last = (r_rp == L_LAST);
endmodule

// File: rtl/layer_mem_ctrl.sv
// Layer memory controller: stores conv results per channel, triggers
// pooling, then streams pooled read pairs. Ports: clk, rst, start,
// busy, done, m (layer_mem_ctrl_if.master).
module layer_mem_ctrl
    import layer_mem_ctrl_pkg::*;
#(
    parameter int W            = 28,
    parameter int OC           = 7,
    parameter int CHANNEL_SIZE = 783,
    parameter int ADDR_LEN     = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    layer_mem_ctrl_if.master  m
);
    localparam int                P_SIZE = pooled_size(W);
    localparam logic [ADDR_LEN:0] L_WLST = (ADDR_LEN + 1)'(CHANNEL_SIZE);
    localparam logic [3:0]        L_CLST = 4'(OC);
    localparam logic [ADDR_LEN:0] L_ONE  = (ADDR_LEN + 1)'(1);

    state_t            r_state;
    state_t            w_next;
    op_t               w_op;
    logic [3:0]        r_out_c;
    logic [ADDR_LEN:0] r_waddr;
    logic              r_pool;
    logic              w_beat;
    logic              w_wlast;
    logic              w_clast;
    logic [ADDR_LEN:0] w_rp;
    logic              w_rp_last;
    logic              w_adv;

    assign w_op    = mem_op(r_state);
    assign w_beat  = (w_op == OP_STORE) && m.conv_valid;
    assign w_wlast = (r_waddr == L_WLST);
    assign w_clast = (r_out_c == L_CLST);
    assign w_adv   = (w_op == OP_LOAD) && m.next_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_STORE;
            end
            S_STORE: begin
                if (w_beat && w_wlast && w_clast) w_next = S_POOL;
            end
            S_POOL: begin
                if (m.pool_done) w_next = S_POOL_CLR;
            end
            S_POOL_CLR: begin
                // Memory must drop its done flag before reads begin.
                if (!m.pool_done) w_next = S_LOAD;
            end
            S_LOAD: begin
                if (w_adv && w_rp_last) w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_c <= '0;
            r_waddr <= '0;
            r_pool  <= 1'b0;
        end else begin
            // Registered so pool rises with entry into POOL.
            r_pool <= (w_next == S_POOL);
            if (r_state == S_IDLE && start) begin
                r_out_c <= '0;
                r_waddr <= '0;
            end else if (w_beat) begin
                if (w_wlast) begin
                    r_waddr <= '0;
                    if (!w_clast) r_out_c <= r_out_c + 4'd1;
                end else begin
                    r_waddr <= r_waddr + L_ONE;
                end
            end
        end
    end

    addr_pair_gen #(
        .ADDR_LEN (ADDR_LEN),
        .LAST     (P_SIZE - 2)
    ) u_apg (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (r_state != S_LOAD),
        .i_adv  (w_adv),
        .o_rp   (w_rp),
        .o_last (w_rp_last)
    );

    assign m.conv_ready = (w_op == OP_STORE);
    assign m.store      = w_beat;
    assign m.out_c      = r_out_c;
    assign m.w_addr     = r_waddr;
    assign m.pool       = r_pool;
    assign m.load       = (w_op == OP_LOAD);
    assign m.addr1      = w_rp;
    assign m.addr2      = w_rp + L_ONE;
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
endmodule

// File: tb/tb_layer_mem_ctrl.sv
// Self-checking bench for layer_mem_ctrl at W=4, OC=1, CHANNEL_SIZE=15.
// Expected values come from beat counts and pair indices.
module tb_layer_mem_ctrl;
    localparam int W     = 4;
    localparam int OC    = 1;
    localparam int CS    = 15;
    localparam int AL    = 9;
    localparam int NCH   = OC + 1;
    localparam int NPAIR = (W / 2) * (W / 2) / 2;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic done;

    int n_chk  = 0;
    int n_fail = 0;

    layer_mem_ctrl_if #(.ADDR_LEN(AL)) bus ();

    layer_mem_ctrl #(
        .W            (W),
        .OC           (OC),
        .CHANNEL_SIZE (CS),
        .ADDR_LEN     (AL)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .m     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_store"}, 32'(bus.store), 0);
        chk({tag, "_rdy"}, 32'(bus.conv_ready), 0);
        chk({tag, "_pool"}, 32'(bus.pool), 0);
        chk({tag, "_load"}, 32'(bus.load), 0);
        chk({tag, "_outc"}, 32'(bus.out_c), 0);
        chk({tag, "_waddr"}, 32'(bus.w_addr), 0);
        chk({tag, "_rp"}, 32'(bus.addr1), 0);
    endtask

    task automatic run_layer(input int mode, input int clr_hold,
                             input int stall_pair, input int stall_len);
        int   beats;
        int   cyc;
        logic v;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("enter_busy", 32'(busy), 1);
        beats = 0;
        cyc   = 0;
        while (beats < NCH * (CS + 1) && cyc < 400) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.conv_valid = v;
            start = (mode == 1 && cyc == 5);
            #1;
            chk("conv_ready", 32'(bus.conv_ready), 1);
            chk("store", 32'(bus.store), 32'(v));
            chk("w_addr", 32'(bus.w_addr), beats % (CS + 1));
            chk("out_c", 32'(bus.out_c), beats / (CS + 1));
            chk("store_pool", 32'(bus.pool), 0);
            tick();
            if (v) beats++;
            cyc++;
        end
        start = 1'b0;
        chk("store_count", beats, NCH * (CS + 1));
        bus.conv_valid = 1'b1;
        #1;
        chk("pool_rise", 32'(bus.pool), 1);
        chk("pool_rdy", 32'(bus.conv_ready), 0);
        chk("pool_store", 32'(bus.store), 0);
        chk("pool_load", 32'(bus.load), 0);
        bus.conv_valid = 1'b0;
        repeat (2) begin
            tick();
            chk("pool_hold", 32'(bus.pool), 1);
        end
        bus.pool_done = 1'b1;
        tick();
        chk("pool_fall", 32'(bus.pool), 0);
        chk("clr_load0", 32'(bus.load), 0);
        repeat (clr_hold) begin
            tick();
            chk("clr_pool", 32'(bus.pool), 0);
            chk("clr_load", 32'(bus.load), 0);
            chk("clr_busy", 32'(busy), 1);
        end
        bus.pool_done = 1'b0;
        tick();
        for (int p = 0; p < NPAIR; p++) begin
            bus.next_ready = 1'b0;
            if (p == stall_pair) begin
                repeat (stall_len) begin
                    #1;
                    chk("stall_load", 32'(bus.load), 1);
                    chk("stall_a1", 32'(bus.addr1), 2 * p);
                    chk("stall_a2", 32'(bus.addr2), 2 * p + 1);
                    chk("stall_done", 32'(done), 0);
                    tick();
                end
            end
            bus.next_ready = 1'b1;
            #1;
            chk("load", 32'(bus.load), 1);
            chk("addr1", 32'(bus.addr1), 2 * p);
            chk("addr2", 32'(bus.addr2), 2 * p + 1);
            chk("load_done", 32'(done), 0);
            tick();
        end
        bus.next_ready = 1'b0;
        start = 1'b1;
        #1;
        chk("done_pulse", 32'(done), 1);
        chk("done_busy", 32'(busy), 1);
        chk("done_load", 32'(bus.load), 0);
        tick();
        start = 1'b0;
        chk("done_fall", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        tick();
        chk("start_in_done_ignored", 32'(busy), 0);
    endtask

    initial begin
        bus.conv_valid = 1'b0;
        bus.pool_done  = 1'b0;
        bus.next_ready = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        chk_quiet("reset");
        rst = 1'b1;
        tick();

        run_layer(0, 0, -1, 0);
        run_layer(1, 3, 1, 5);
        run_layer(2, $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(1, 4));

        start = 1'b1;
        tick();
        start = 1'b0;
        bus.conv_valid = 1'b1;
        repeat (7) tick();
        chk("mid_waddr", 32'(bus.w_addr), 7);
        chk("mid_store", 32'(bus.store), 1);
        rst = 1'b0;
        #1;
        chk_quiet("abort");
        tick();
        rst = 1'b1;
        bus.conv_valid = 1'b0;
        tick();
        chk("need_start", 32'(busy), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_busy", 32'(busy), 1);
        chk("restart_waddr", 32'(bus.w_addr), 0);
        chk("restart_outc", 32'(bus.out_c), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/layer_mem_ctrl.md
LAYER_MEM_CTRL -- requirements
Module: layer_mem_ctrl

Interface
REQ-001 Parameter W, default 28: feature-map width, which is also the height; it SHALL be even.
REQ-002 Parameter OC, default 7: index of the last output channel, giving OC+1 channels.
REQ-003 Parameter CHANNEL_SIZE, default 783: index of the last word in a channel, equal to W*W-1.
REQ-004 Parameter ADDR_LEN, default 9: MSB index of every address port.
REQ-005 clk  in  1  single clock for the block; all state SHALL change on the rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-low.
REQ-007 start  in  1  one-cycle request to begin a layer; ignored unless the block is in IDLE.
REQ-008 conv_valid  in  1  producer has a convolution result available.
REQ-009 conv_ready  out  1  controller accepts a result this cycle.
REQ-010 store  out  1  write strobe to the layer memory.
REQ-011 out_c  out  4  channel to write.
REQ-012 w_addr  out  ADDR_LEN+1  write address.
REQ-013 pool  out  1  pooling enable to the layer memory.
REQ-014 pool_done  in  1  layer memory reports pooling complete.
REQ-015 load  out  1  read enable to the layer memory.
REQ-016 addr1, addr2  out  ADDR_LEN+1 each  read address pair.
REQ-017 next_ready  in  1  consumer accepts the current read pair.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse at the end of the layer.

Function
REQ-020 The FSM SHALL have states IDLE, STORE, POOL, POOL_CLR, LOAD, DONE, encoded as in the shared package.
REQ-021 IDLE: on start=1 the FSM SHALL go to STORE with out_c=0 and w_addr=0.
REQ-022 STORE: conv_ready SHALL be 1 and store SHALL equal conv_valid, combinationally; a beat is conv_valid & conv_ready.
REQ-023 Each beat SHALL increment w_addr by 1.
REQ-024 On a beat at w_addr==CHANNEL_SIZE, w_addr SHALL wrap to 0 and out_c SHALL increment.
REQ-025 On a beat at w_addr==CHANNEL_SIZE with out_c==OC, the FSM SHALL go to POOL instead.
REQ-026 A stalled producer (conv_valid=0) SHALL hold out_c and w_addr unchanged, with no timeout.
REQ-027 POOL: pool SHALL be registered high for every cycle in POOL, starting the cycle after the last store.
REQ-028 POOL: on pool_done=1 the FSM SHALL go to POOL_CLR, and pool SHALL be 0 from the next cycle.
REQ-029 POOL_CLR: pool SHALL stay 0, and the FSM SHALL wait until pool_done==0 (memory handshake clear) before going to LOAD.
REQ-030 LOAD: load SHALL be 1, addr1 SHALL be the read pointer rp, and addr2 SHALL equal rp+1; rp SHALL be 0 on entry.
REQ-031 LOAD: on next_ready=1, rp SHALL advance by 2.
REQ-032 LOAD: on next_ready=1 with rp==(W/2)*(W/2)-2, the FSM SHALL go to DONE.
REQ-033 DONE: done SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-034 Outside STORE, conv_ready and store SHALL be 0; outside LOAD, load SHALL be 0.
REQ-035 A start asserted in the same cycle as DONE SHALL be ignored, because the FSM is not yet in IDLE.
REQ-036 All counters SHALL be full width, and no address SHALL exceed CHANNEL_SIZE.

Reset
REQ-037 While rst==0, the FSM SHALL be IDLE and out_c, w_addr, rp, pool, load, done and busy SHALL be 0.
REQ-038 Reset asserted mid-operation SHALL abort the layer with no further store/pool/load strobes; a fresh start SHALL be required.

Structure
REQ-039 The FSM state type, opcodes and the derived constant POOLED_SIZE=(W/2)*(W/2) SHALL live in the shared CNN package.
REQ-040 One sub-module, addr_pair_gen, SHALL implement the rp counter for LOAD.
REQ-041 Target implementation size is 120-400 lines of RTL.

Verification
REQ-042 The bench SHALL use W=4, OC=1, CHANNEL_SIZE=15 for all scenarios below.
REQ-043 Full flow: start, then 32 back-to-back beats -> out_c 0 then 1, w_addr 0..15 twice, pool high the next cycle, and after pool_done then pool_done low: load with pairs (0,1),(2,3), then done for one cycle.
REQ-044 Producer stalls: conv_valid toggled 1,0,0,1 -> w_addr advances only on the valid cycles and total stores is 32.
REQ-045 start asserted while busy (in STORE) -> no state change, and counters continue.
REQ-046 pool_done held high for 3 cycles after pool falls -> FSM stays in POOL_CLR with load=0 until pool_done is low.
REQ-047 rst pulsed low mid-STORE at w_addr=7 -> all outputs 0 immediately; a new start restarts at out_c=0, w_addr=0.
REQ-048 next_ready low for 5 cycles in LOAD -> addr1/addr2 held at (2,3), and done occurs only after acceptance.
